fifo_rd_stream: RTL
===================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 SHALL have parameter c_DATA_WIDTH, default 8, width of the FIFO read data and the stream data.
REQ-002 SHALL have parameter c_RD_LATENCY, default 1, cycles from fifo_rd_en to valid fifo_rd_data; legal values are 1 (c_OUTPUT_REG=0) and 2 (c_OUTPUT_REG=1).
REQ-003 SHALL have parameter c_FRAME_LEN, default 256, beats per frame for m_last; legal range is 2..65536.
REQ-004 SHALL have port rd_clk, input, 1 bit: the single clock, the FIFO read clock.
REQ-005 SHALL have port rd_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port fifo_rd_en, output, 1 bit: read enable driving the FIFO rd_en.
REQ-007 SHALL have port fifo_rd_empty, input, 1 bit: FIFO empty flag.
REQ-008 SHALL have port fifo_rd_data, input, c_DATA_WIDTH bits: FIFO read data.
REQ-009 SHALL have port m_valid, output, 1 bit: stream data valid.
REQ-010 SHALL have port m_ready, input, 1 bit: stream sink ready.
REQ-011 SHALL have port m_data, output, c_DATA_WIDTH bits: stream data.
REQ-012 SHALL have port m_last, output, 1 bit: last beat of a frame.
REQ-013 SHALL have port occupancy, output, 2 bits: held words plus in-flight words.

Function
REQ-014 SHALL use a transfer rule: a beat transfers (pop) on a rising rd_clk edge when m_valid=1 and m_ready=1.
REQ-015 SHALL contain a skid store of DEPTH=c_RD_LATENCY+1 entries, organised as an in-order circular buffer with wrapping pointers.
REQ-016 SHALL maintain occ = stored + in-flight, and never let occ exceed DEPTH.
REQ-017 SHALL drive fifo_rd_en = !fifo_rd_empty && (occ<DEPTH || pop); fifo_rd_en is combinational and is 0 while rd_rst=1.
REQ-018 SHALL track in-flight reads with a c_RD_LATENCY-stage valid shift register; when a stage exits, fifo_rd_data is captured into the store on that edge.
REQ-019 SHALL drive m_valid = (stored>0) and m_data = the head entry; m_data SHALL be stable while m_valid=1 and m_ready=0.
REQ-020 SHALL sustain one beat per cycle with continuous m_ready=1 and a non-empty FIFO; first-word latency from fifo_rd_empty falling to m_valid SHALL be c_RD_LATENCY+1 cycles.
REQ-021 SHALL handle a simultaneous capture and pop in one cycle with stored unchanged and both pointers advancing.
REQ-022 SHALL present occupancy = occ, registered.
REQ-023 SHALL issue no new reads while m_ready=0 and occ=DEPTH; all words already read SHALL be retained without loss.
REQ-024 SHALL never assert fifo_rd_en while fifo_rd_empty=1, which gives underflow protection.

Reset
REQ-025 SHALL, while rd_rst=1, clear: m_valid=0, m_data=0, m_last=0, occupancy=0, pointers=0, valid pipe=0, beat counter=0.
REQ-026 SHALL discard words in flight when rd_rst asserts mid-operation; the FIFO is reset in the same domain, so no recovery is needed.
REQ-027 SHALL apply reset asynchronously on assertion, with release sampled on rd_clk; the first fifo_rd_en may occur in the first cycle after release.

Configuration
REQ-028 SHALL use macro FIFO_RD_STREAM_LAST_EN to select frame marking.
REQ-029 SHALL, with FIFO_RD_STREAM_LAST_EN defined, use a 16-bit beat counter that increments per pop and wraps to 0 after beat c_FRAME_LEN-1; m_last = m_valid && (count==c_FRAME_LEN-1).
REQ-030 SHALL, without FIFO_RD_STREAM_LAST_EN, tie m_last to 0 and omit the counter logic.

Verification
REQ-031 SHALL verify: c_RD_LATENCY=1, 4 words 0x11..0x14 preloaded, m_ready=1 -> m_valid rises 2 cycles after first fifo_rd_en, then 0x11..0x14 on consecutive cycles.
REQ-032 SHALL verify: c_RD_LATENCY=2, 10 words, m_ready toggling 1,0,0,1 repeating -> all 10 words in order, none dropped or duplicated, occupancy never >3.
REQ-033 SHALL verify: FIFO holding 1 word, m_ready=1 -> exactly one fifo_rd_en, and no fifo_rd_en while fifo_rd_empty=1.
REQ-034 SHALL verify: m_ready=0 with a full FIFO -> fifo_rd_en stops once occupancy=DEPTH, and m_data holds 0x11.
REQ-035 SHALL verify: rd_rst pulsed mid-burst with occupancy=2 -> m_valid=0, m_data=0, occupancy=0 in the same cycle, and correct restart after release.
REQ-036 SHALL verify: FIFO_RD_STREAM_LAST_EN defined, c_FRAME_LEN=4, 8 beats -> m_last=1 on beats 4 and 8 only; macro undefined -> m_last stays 0.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read side of a synchronous FIFO turned into a valid/ready stream through a small skid store.
// Frame marking on m_last is built only when FIFO_RD_STREAM_LAST_EN is defined.
module fifo_rd_stream #(
  parameter int c_DATA_WIDTH = 8,
  parameter int c_RD_LATENCY = 1,
  parameter int c_FRAME_LEN  = 256
) (
  input  logic                    rd_clk,
  input  logic                    rd_rst,
  output logic                    fifo_rd_en,
  input  logic                    fifo_rd_empty,
  input  logic [c_DATA_WIDTH-1:0] fifo_rd_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [c_DATA_WIDTH-1:0] m_data,
  output logic                    m_last,
  output logic [1:0]              occupancy
);

  localparam int         DEPTH   = c_RD_LATENCY + 1;
  localparam int         PW      = $clog2(DEPTH);
  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  typedef logic [PW-1:0] ptr_t;

  if (c_RD_LATENCY < 1 || c_RD_LATENCY > 2) begin : g_bad_latency
    $error("fifo_rd_stream: c_RD_LATENCY must be 1 or 2");
  end
  if (c_FRAME_LEN < 2 || c_FRAME_LEN > 65536) begin : g_bad_frame_len
    $error("fifo_rd_stream: c_FRAME_LEN must be in 2..65536");
  end

  logic [c_DATA_WIDTH-1:0] mem_q [DEPTH];
  ptr_t                    wr_ptr_q, wr_ptr_d;
  ptr_t                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              stored_q, stored_d;
  logic [1:0]              occ_q, occ_d;
  logic [c_RD_LATENCY-1:0] pipe_q, pipe_d;
  logic                    pop;
  logic                    capture;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign pop       = m_valid && m_ready;
  assign capture   = pipe_q[c_RD_LATENCY-1];
  assign m_valid   = (stored_q != 2'd0);
  assign m_data    = mem_q[rd_ptr_q];
  assign occupancy = occ_q;

  // A pop in this cycle frees a slot, so a full store may still issue a read.
  assign fifo_rd_en = !rd_rst && !fifo_rd_empty && ((occ_q < DEPTH_C) || pop);

  always_comb begin
    pipe_d   = (pipe_q << 1) | c_RD_LATENCY'(fifo_rd_en);
    stored_d = stored_q + {1'b0, capture} - {1'b0, pop};
    occ_d    = occ_q + {1'b0, fifo_rd_en} - {1'b0, pop};
    wr_ptr_d = capture ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      pipe_q   <= '0;
      stored_q <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      pipe_q   <= pipe_d;
      stored_q <= stored_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (capture) mem_q[wr_ptr_q] <= fifo_rd_data;
    end
  end

`ifdef FIFO_RD_STREAM_LAST_EN
  localparam logic [15:0] LAST_BEAT = 16'(c_FRAME_LEN - 1);

  logic [15:0] beat_q, beat_d;

  always_comb begin
    beat_d = beat_q;
    if (pop) beat_d = (beat_q == LAST_BEAT) ? 16'd0 : beat_q + 16'd1;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) beat_q <= '0;
    else        beat_q <= beat_d;
  end

  assign m_last = m_valid && (beat_q == LAST_BEAT);
`else
  assign m_last = 1'b0;
`endif

endmodule
